// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: operands/controls in, registered ALU results out.
// Optional overflow signal present when ALU_OVERFLOW_DET_EN is defined.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             branch;
    logic             out_valid;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;
    logic             illegal_funct;
`ifdef ALU_OVERFLOW_DET_EN
    logic             overflow;
`endif

    modport master (
        output in_valid, alu_op, funct, op_a, op_b, branch,
`ifdef ALU_OVERFLOW_DET_EN
        input  overflow,
`endif
        input  out_valid, alu_ctl, result, zero,
        input  branch_taken, illegal_funct
    );

    modport slave (
        input  in_valid, alu_op, funct, op_a, op_b, branch,
`ifdef ALU_OVERFLOW_DET_EN
        output overflow,
`endif
        output out_valid, alu_ctl, result, zero,
        output branch_taken, illegal_funct
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered MIPS-subset execute stage: ALU-control decode, ALU, branch gate.
// Define ALU_OVERFLOW_DET_EN to add the registered signed-overflow flag.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    alu_exec_stage_if.slave bus
);
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    logic [3:0]       ctl;
    logic             illegal;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             is_zero;
    logic             slt_bit;

    always_comb begin
        ctl     = CTL_ADD;
        illegal = 1'b0;
        unique case (bus.alu_op)
            2'b00: ctl = CTL_ADD;
            2'b01: ctl = CTL_SUB;
            2'b11: ctl = CTL_ADD;
            2'b10: begin
                unique case (1'b1)
                    (bus.funct == 6'b100000),
                    (bus.funct == 6'b100001): ctl = CTL_ADD;
                    (bus.funct == 6'b100010),
                    (bus.funct == 6'b100011): ctl = CTL_SUB;
                    (bus.funct == 6'b100100): ctl = CTL_AND;
                    (bus.funct == 6'b100101): ctl = CTL_OR;
                    (bus.funct == 6'b101010): ctl = CTL_SLT;
                    (bus.funct == 6'b100111): ctl = CTL_NOR;
                    default: begin
                        ctl     = CTL_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: ctl = CTL_ADD;
        endcase
    end

    assign sum     = bus.op_a + bus.op_b;
    assign diff    = bus.op_a - bus.op_b;
    assign slt_bit = $signed(bus.op_a) < $signed(bus.op_b);

    always_comb begin
        res = '0;
        case (ctl)
            CTL_AND: res = bus.op_a & bus.op_b;
            CTL_OR:  res = bus.op_a | bus.op_b;
            CTL_ADD: res = sum;
            CTL_SUB: res = diff;
            CTL_SLT: res = {{(WIDTH-1){1'b0}}, slt_bit};
            CTL_NOR: res = ~(bus.op_a | bus.op_b);
            default: res = '0;
        endcase
    end

    assign is_zero = (res == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.alu_ctl       <= 4'b0000;
            bus.result        <= '0;
            bus.zero          <= 1'b0;
            bus.branch_taken  <= 1'b0;
            bus.illegal_funct <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.alu_ctl       <= ctl;
                bus.result        <= res;
                bus.zero          <= is_zero;
                bus.branch_taken  <= bus.branch & is_zero;
                bus.illegal_funct <= illegal;
            end
        end
    end

`ifdef ALU_OVERFLOW_DET_EN
    logic ovf;
    logic sa;
    logic sb;

    assign sa = bus.op_a[WIDTH-1];
    assign sb = bus.op_b[WIDTH-1];

    always_comb begin
        ovf = 1'b0;
        if (ctl == CTL_ADD)
            ovf = (sa == sb) && (sum[WIDTH-1] != sa);
        else if (ctl == CTL_SUB)
            ovf = (sa != sb) && (diff[WIDTH-1] != sa);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.overflow <= 1'b0;
        else if (bus.in_valid)
            bus.overflow <= ovf;
    end
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors, queue-based checker.
// Overflow expectations are checked only when ALU_OVERFLOW_DET_EN is defined.
module tb_alu_exec_stage;
    localparam int W = 32;

    typedef struct packed {
        logic [3:0]   ctl;
        logic [W-1:0] res;
        logic         zero;
        logic         taken;
        logic         ill;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    alu_exec_stage_if #(.WIDTH(W)) bus ();

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic br, input logic [3:0] ectl,
                         input logic [W-1:0] eres, input logic eill,
                         input logic eovf);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.funct    = fn;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.branch   = br;
        e.ctl   = ectl;
        e.res   = eres;
        e.zero  = (eres == '0);
        e.taken = br & (eres == '0);
        e.ill   = eill;
        e.ovf   = eovf;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", sb_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("alu_ctl", W'(bus.alu_ctl), W'(e.ctl));
                check("result", bus.result, e.res);
                check("zero", W'(bus.zero), W'(e.zero));
                check("branch_taken", W'(bus.branch_taken), W'(e.taken));
                check("illegal_funct", W'(bus.illegal_funct), W'(e.ill));
`ifdef ALU_OVERFLOW_DET_EN
                check("overflow", W'(bus.overflow), W'(e.ovf));
`endif
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, W'(bus.out_valid), '0);
        check({tag, "_alu_ctl"}, W'(bus.alu_ctl), '0);
        check({tag, "_result"}, bus.result, '0);
        check({tag, "_zero"}, W'(bus.zero), '0);
        check({tag, "_taken"}, W'(bus.branch_taken), '0);
        check({tag, "_illegal"}, W'(bus.illegal_funct), '0);
`ifdef ALU_OVERFLOW_DET_EN
        check({tag, "_overflow"}, W'(bus.overflow), '0);
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.branch   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // add 5+7, then async reset in mid-cycle must clear it at once
        issue(2'b10, 6'b100000, 32'd5, 32'd7, 1'b0, 4'b0010, 32'd12, 1'b0, 1'b0);
        idle();
        drain();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        #1;
        rst = 1'b0;

        issue(2'b01, 6'b000000, 32'h1234, 32'h1234, 1'b1, 4'b0110, 32'h0, 1'b0, 1'b0);
        issue(2'b01, 6'b000000, 32'h1234, 32'h1235, 1'b1, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 1'b0, 4'b0111, 32'h1, 1'b0, 1'b0);
        issue(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF, 1'b0, 4'b0111, 32'h0, 1'b0, 1'b0);
        issue(2'b10, 6'b101010, 32'h80000000, 32'h1, 1'b0, 4'b0111, 32'h1, 1'b0, 1'b0);
        issue(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b0000, 32'hF000F000, 1'b0, 1'b0);
        issue(2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
        issue(2'b10, 6'b100101, 32'h00FF0000, 32'h000000FF, 1'b1, 4'b0001, 32'h00FF00FF, 1'b0, 1'b0);
        issue(2'b10, 6'b100111, 32'h0, 32'h0, 1'b0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(2'b10, 6'b000000, 32'd3, 32'd4, 1'b0, 4'b0010, 32'd7, 1'b1, 1'b0);
        issue(2'b10, 6'b100011, 32'h80000000, 32'h1, 1'b0, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
        issue(2'b11, 6'b111111, 32'hFFFFFFFF, 32'h1, 1'b1, 4'b0010, 32'h0, 1'b0, 1'b0);
        issue(2'b00, 6'b000000, 32'h7FFFFFFF, 32'h1, 1'b0, 4'b0010, 32'h80000000, 1'b0, 1'b1);

        // two idle cycles: outputs hold, out_valid drops
        idle();
        @(negedge clk);
        idle();
        @(negedge clk);
        check("hold1_out_valid", W'(bus.out_valid), '0);
        check("hold1_result", bus.result, 32'h80000000);
        check("hold1_alu_ctl", W'(bus.alu_ctl), W'(4'b0010));
        @(negedge clk);
        check("hold2_out_valid", W'(bus.out_valid), '0);
        check("hold2_result", bus.result, 32'h80000000);
`ifdef ALU_OVERFLOW_DET_EN
        check("hold2_overflow", W'(bus.overflow), W'(1'b1));
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded limit");
        $fatal(1, "timeout");
    end
endmodule
